// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoding constants: op ids, opcode/funct fields, immediate limits and
// field-packing helpers used by the instruction encoder.
package rv_enc_pkg;

  // Symbolic op ids accepted on in_op; 22..31 are illegal.
  localparam logic [4:0] OpAdd  = 5'd0;
  localparam logic [4:0] OpSub  = 5'd1;
  localparam logic [4:0] OpAnd  = 5'd2;
  localparam logic [4:0] OpOr   = 5'd3;
  localparam logic [4:0] OpXor  = 5'd4;
  localparam logic [4:0] OpSll  = 5'd5;
  localparam logic [4:0] OpSrl  = 5'd6;
  localparam logic [4:0] OpSra  = 5'd7;
  localparam logic [4:0] OpAddi = 5'd8;
  localparam logic [4:0] OpAndi = 5'd9;
  localparam logic [4:0] OpOri  = 5'd10;
  localparam logic [4:0] OpXori = 5'd11;
  localparam logic [4:0] OpSlli = 5'd12;
  localparam logic [4:0] OpSrli = 5'd13;
  localparam logic [4:0] OpSrai = 5'd14;
  localparam logic [4:0] OpLw   = 5'd15;
  localparam logic [4:0] OpJalr = 5'd16;
  localparam logic [4:0] OpSw   = 5'd17;
  localparam logic [4:0] OpBeq  = 5'd18;
  localparam logic [4:0] OpBne  = 5'd19;
  localparam logic [4:0] OpLui  = 5'd20;
  localparam logic [4:0] OpJal  = 5'd21;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3SrlSra = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;
  localparam logic [2:0] F3Word   = 3'b010;
  localparam logic [2:0] F3Jalr   = 3'b000;
  localparam logic [2:0] F3Beq    = 3'b000;
  localparam logic [2:0] F3Bne    = 3'b001;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  localparam int ImmIMin  = -2048;
  localparam int ImmIMax  = 2047;
  localparam int ShamtMin = 0;
  localparam int ShamtMax = 31;
  localparam int ImmBMin  = -4096;
  localparam int ImmBMax  = 4094;
  localparam int ImmJMin  = -1048576;
  localparam int ImmJMax  = 1048574;

  typedef struct packed {
    logic        legal;
    logic [31:0] inst;
  } enc_result_t;

  function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, OpcOp};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, F3Word, imm[4:0], OpcStore};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OpcBranch};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpcJal};
  endfunction

endpackage

// File: rtl/rv_enc_fifo2.sv
// Two-entry valid/ready FIFO; push while full is allowed when the head pops the same cycle.
module rv_enc_fifo2 #(
  parameter int unsigned       Width    = 64,
  parameter logic [Width-1:0]  ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [Width-1:0] wr_data_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [Width-1:0] rd_data_o
);

  logic [1:0][Width-1:0] mem_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q;
  logic                  push, pop;

  assign rd_valid_o = (cnt_q != 2'd0);
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign pop        = rd_valid_o & rd_ready_i;
  assign wr_ready_o = (cnt_q != 2'd2) | pop;
  assign push       = wr_valid_i & wr_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= {2{ResetVal}};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (clear_i) begin
      mem_q    <= {2{ResetVal}};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/rv_inst_encoder.sv
// Encodes symbolic RV32I requests into machine words and streams them, tagged with
// sequential byte addresses, toward the instruction-memory loader.
module rv_inst_encoder
  import rv_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 64
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        full,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned     CntW     = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  function automatic enc_result_t encode(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [31:0] imm);
    enc_result_t r;
    logic        i_ok, sh_ok, b_ok, j_ok, u_ok;
    i_ok    = in_range(imm, ImmIMin, ImmIMax);
    sh_ok   = in_range(imm, ShamtMin, ShamtMax);
    b_ok    = in_range(imm, ImmBMin, ImmBMax) & ~imm[0];
    j_ok    = in_range(imm, ImmJMin, ImmJMax) & ~imm[0];
    u_ok    = (imm[31:20] == 12'h000);
    r.legal = 1'b0;
    r.inst  = '0;
    case (op)
      OpAdd:  begin r.legal = 1'b1;  r.inst = enc_r(F7Base, F3AddSub, rd, rs1, rs2); end
      OpSub:  begin r.legal = 1'b1;  r.inst = enc_r(F7Alt, F3AddSub, rd, rs1, rs2);  end
      OpAnd:  begin r.legal = 1'b1;  r.inst = enc_r(F7Base, F3And, rd, rs1, rs2);    end
      OpOr:   begin r.legal = 1'b1;  r.inst = enc_r(F7Base, F3Or, rd, rs1, rs2);     end
      OpXor:  begin r.legal = 1'b1;  r.inst = enc_r(F7Base, F3Xor, rd, rs1, rs2);    end
      OpSll:  begin r.legal = 1'b1;  r.inst = enc_r(F7Base, F3Sll, rd, rs1, rs2);    end
      OpSrl:  begin r.legal = 1'b1;  r.inst = enc_r(F7Base, F3SrlSra, rd, rs1, rs2); end
      OpSra:  begin r.legal = 1'b1;  r.inst = enc_r(F7Alt, F3SrlSra, rd, rs1, rs2);  end
      OpAddi: begin r.legal = i_ok;  r.inst = enc_i(imm[11:0], rs1, F3AddSub, rd, OpcOpImm); end
      OpAndi: begin r.legal = i_ok;  r.inst = enc_i(imm[11:0], rs1, F3And, rd, OpcOpImm);    end
      OpOri:  begin r.legal = i_ok;  r.inst = enc_i(imm[11:0], rs1, F3Or, rd, OpcOpImm);     end
      OpXori: begin r.legal = i_ok;  r.inst = enc_i(imm[11:0], rs1, F3Xor, rd, OpcOpImm);    end
      // Shift-immediates carry funct7 in the upper bits of the I-type immediate slot.
      OpSlli: begin
        r.legal = sh_ok;
        r.inst  = enc_i({F7Base, imm[4:0]}, rs1, F3Sll, rd, OpcOpImm);
      end
      OpSrli: begin
        r.legal = sh_ok;
        r.inst  = enc_i({F7Base, imm[4:0]}, rs1, F3SrlSra, rd, OpcOpImm);
      end
      OpSrai: begin
        r.legal = sh_ok;
        r.inst  = enc_i({F7Alt, imm[4:0]}, rs1, F3SrlSra, rd, OpcOpImm);
      end
      OpLw:   begin r.legal = i_ok;  r.inst = enc_i(imm[11:0], rs1, F3Word, rd, OpcLoad); end
      OpJalr: begin r.legal = i_ok;  r.inst = enc_i(imm[11:0], rs1, F3Jalr, rd, OpcJalr); end
      OpSw:   begin r.legal = i_ok;  r.inst = enc_s(imm[11:0], rs2, rs1);                 end
      OpBeq:  begin r.legal = b_ok;  r.inst = enc_b(imm[12:1], rs2, rs1, F3Beq);          end
      OpBne:  begin r.legal = b_ok;  r.inst = enc_b(imm[12:1], rs2, rs1, F3Bne);          end
      OpLui:  begin r.legal = u_ok;  r.inst = {imm[19:0], rd, OpcLui};                    end
      OpJal:  begin r.legal = j_ok;  r.inst = enc_j(imm[20:1], rd);                       end
      default: begin
        r.legal = 1'b0;
        r.inst  = '0;
      end
    endcase
    return r;
  endfunction

  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     addr_q, addr_d;
  logic            err_q, err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  enc_result_t     enc;
  logic            fifo_wr_ready, accept, push;
  logic [63:0]     fifo_rd_data;

  assign enc      = encode(in_op, in_rd, in_rs1, in_rs2, in_imm);
  assign full     = (count_q == DepthCnt);
  // Gate with resetn so the host never sees a handshake while reset is held.
  assign in_ready = resetn & ~clear & ~full & fifo_wr_ready;
  assign accept   = in_valid & in_ready;
  assign push     = accept & enc.legal;

  always_comb begin
    count_d   = count_q;
    addr_d    = addr_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (clear) begin
      count_d   = '0;
      addr_d    = BASE_ADDR;
      err_d     = 1'b0;
      err_cnt_d = 8'd0;
    end else if (accept) begin
      if (enc.legal) begin
        count_d = count_q + CntW'(1);
        addr_d  = addr_q + 32'd4;
      end else begin
        err_d = 1'b1;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q   <= '0;
      addr_q    <= BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      count_q   <= count_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  rv_enc_fifo2 #(
    .Width    (64),
    .ResetVal ({BASE_ADDR, 32'h0000_0000})
  ) u_fifo (
    .clk_i      (clock),
    .rst_ni     (resetn),
    .clear_i    (clear),
    .wr_valid_i (push),
    .wr_ready_o (fifo_wr_ready),
    .wr_data_i  ({addr_q, enc.inst}),
    .rd_valid_o (out_valid),
    .rd_ready_i (out_ready),
    .rd_data_o  (fifo_rd_data)
  );

  assign out_addr = fifo_rd_data[63:32];
  assign out_inst = fifo_rd_data[31:0];
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Scoreboard bench for rv_inst_encoder: DUT a (DEPTH=64) and DUT b (DEPTH=4) share
// clock, reset, clear and request fields; each has its own valid/ready and expected queue.
module tb_rv_inst_encoder;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        clear = 1'b0;
  logic [4:0]  in_op = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic        out_ready_a = 1'b0, out_ready_b = 1'b0;
  logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic [31:0] out_inst_a, out_inst_b, out_addr_a, out_addr_b;
  logic        full_a, full_b, err_a, err_b;
  logic [7:0]  err_cnt_a, err_cnt_b;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] qa[$];
  logic [63:0] qb[$];

  always #5 clock = ~clock;

  rv_inst_encoder #(.BASE_ADDR(32'h0), .DEPTH(64)) dut_a (
    .clock(clock), .resetn(resetn), .clear(clear),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_inst(out_inst_a),
    .out_addr(out_addr_a), .full(full_a), .err(err_a), .err_cnt(err_cnt_a)
  );

  rv_inst_encoder #(.BASE_ADDR(32'h0), .DEPTH(4)) dut_b (
    .clock(clock), .resetn(resetn), .clear(clear),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_inst(out_inst_b),
    .out_addr(out_addr_b), .full(full_b), .err(err_b), .err_cnt(err_cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: pops the expected word whenever a DUT hands one to the loader.
  task automatic mon(input int d, input logic [31:0] inst, input logic [31:0] addr);
    logic [63:0] e;
    if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
      n_checks++;
      $display("FAIL dut%0d unexpected word: got 0x%08h@0x%08h, expected none", d, inst, addr);
    end else begin
      e = (d == 0) ? qa.pop_front() : qb.pop_front();
      check($sformatf("dut%0d word inst", d), inst, e[31:0]);
      check($sformatf("dut%0d word addr", d), addr, e[63:32]);
    end
  endtask

  always @(negedge clock) begin
    if (out_valid_a && out_ready_a) mon(0, out_inst_a, out_addr_a);
    if (out_valid_b && out_ready_b) mon(1, out_inst_b, out_addr_b);
  end

  task automatic drive(input int d, input logic [4:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    if (d == 0) in_valid_a = 1'b1;
    else        in_valid_b = 1'b1;
  endtask

  // Waits for the handshake; expected word enters the scoreboard just before the accept edge.
  task automatic wait_accept(input int d, input logic legal, input logic [31:0] inst,
                             input logic [31:0] addr, input string name);
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      if ((d == 0 && in_ready_a) || (d == 1 && in_ready_b)) begin
        if (legal) begin
          if (d == 0) qa.push_back({addr, inst});
          else        qb.push_back({addr, inst});
        end
        done = 1'b1;
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL %s accept: in_ready stayed 0 for 50 cycles, expected 1", name);
    end
    @(posedge clock); #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic req(input int d, input logic [4:0] op, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                     input logic legal, input logic [31:0] inst, input logic [31:0] addr,
                     input string name);
    drive(d, op, rd, rs1, rs2, imm);
    wait_accept(d, legal, inst, addr, name);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("reset in_ready", {31'b0, in_ready_a}, 32'd0);
    check("reset out_valid", {31'b0, out_valid_a}, 32'd0);
    check("reset out_inst", out_inst_a, 32'h0);
    check("reset out_addr", out_addr_a, 32'h0);
    check("reset full", {31'b0, full_a}, 32'd0);
    check("reset err", {31'b0, err_a}, 32'd0);
    check("reset err_cnt", {24'b0, err_cnt_a}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); #1;
    check("post-reset in_ready", {31'b0, in_ready_a}, 32'd1);

    // Directed legal encodes, addresses 0..28
    out_ready_a = 1'b1;
    req(0, 5'd0,  5'd3, 5'd1, 5'd2, 32'd0,          1, 32'h002081B3, 32'd0,  "add");
    req(0, 5'd1,  5'd3, 5'd1, 5'd2, 32'd0,          1, 32'h402081B3, 32'd4,  "sub");
    req(0, 5'd8,  5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF,  1, 32'hFFF00093, 32'd8,  "addi");
    req(0, 5'd15, 5'd5, 5'd2, 5'd0, 32'd8,          1, 32'h00812283, 32'd12, "lw");
    req(0, 5'd17, 5'd0, 5'd2, 5'd5, 32'd8,          1, 32'h00512423, 32'd16, "sw");
    req(0, 5'd18, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8,  1, 32'hFE208CE3, 32'd20, "beq");
    req(0, 5'd21, 5'd1, 5'd0, 5'd0, 32'd16,         1, 32'h010000EF, 32'd24, "jal");
    req(0, 5'd20, 5'd7, 5'd0, 5'd0, 32'h0001_2345,  1, 32'h123453B7, 32'd28, "lui");
    idle(3);

    // Backpressure: two words fill the FIFO, the third waits
    out_ready_a = 1'b0;
    do_clear();
    req(0, 5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h002081B3, 32'd0, "bp add");
    req(0, 5'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h402081B3, 32'd4, "bp sub");
    drive(0, 5'd8, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp in_ready", {31'b0, in_ready_a}, 32'd0);
      check("bp head valid", {31'b0, out_valid_a}, 32'd1);
      check("bp head inst", out_inst_a, 32'h002081B3);
      check("bp head addr", out_addr_a, 32'd0);
    end
    @(posedge clock); #1;
    out_ready_a = 1'b1;
    wait_accept(0, 1, 32'hFFF00093, 32'd8, "bp addi");
    idle(3);

    // Illegal requests are consumed without emitting a word
    do_clear();
    req(0, 5'd8,  5'd1, 5'd0, 5'd0, 32'd2048, 0, 32'h0, 32'h0, "ill addi");
    req(0, 5'd18, 5'd0, 5'd1, 5'd2, 32'd3,    0, 32'h0, 32'h0, "ill beq");
    req(0, 5'd25, 5'd1, 5'd1, 5'd1, 32'd0,    0, 32'h0, 32'h0, "ill op");
    check("ill err", {31'b0, err_a}, 32'd1);
    check("ill err_cnt", {24'b0, err_cnt_a}, 32'd3);
    req(0, 5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h002081B3, 32'd0, "post-ill add");
    idle(3);
    do_clear();
    check("clear err", {31'b0, err_a}, 32'd0);
    check("clear err_cnt", {24'b0, err_cnt_a}, 32'd0);

    // Full on DEPTH=4, then clear with a request pending and out_ready low
    out_ready_b = 1'b1;
    req(1, 5'd8, 5'd1, 5'd0, 5'd0, 32'd1, 1, 32'h00100093, 32'd0,  "full w0");
    req(1, 5'd8, 5'd1, 5'd0, 5'd0, 32'd2, 1, 32'h00200093, 32'd4,  "full w1");
    req(1, 5'd8, 5'd1, 5'd0, 5'd0, 32'd3, 1, 32'h00300093, 32'd8,  "full w2");
    req(1, 5'd8, 5'd1, 5'd0, 5'd0, 32'd4, 1, 32'h00400093, 32'd12, "full w3");
    idle(3);
    check("full flag", {31'b0, full_b}, 32'd1);
    drive(1, 5'd8, 5'd1, 5'd0, 5'd0, 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("full in_ready", {31'b0, in_ready_b}, 32'd0);
    end
    @(posedge clock); #1;
    out_ready_b = 1'b0;
    clear = 1'b1;
    @(negedge clock);
    check("clear-cycle in_ready", {31'b0, in_ready_b}, 32'd0);
    @(posedge clock); #1;
    clear = 1'b0;
    check("post-clear full", {31'b0, full_b}, 32'd0);
    check("post-clear out_valid", {31'b0, out_valid_b}, 32'd0);
    wait_accept(1, 1, 32'h00500093, 32'd0, "post-clear addi");
    out_ready_b = 1'b1;
    idle(3);

    // Async reset with two words held in the FIFO
    out_ready_a = 1'b0;
    do_clear();
    req(0, 5'd25, 5'd0, 5'd0, 5'd0, 32'd0, 0, 32'h0, 32'h0, "rst ill");
    req(0, 5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h002081B3, 32'd0, "rst add");
    req(0, 5'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h402081B3, 32'd4, "rst sub");
    check("pre-rst err_cnt", {24'b0, err_cnt_a}, 32'd1);
    check("pre-rst out_valid", {31'b0, out_valid_a}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("async out_valid", {31'b0, out_valid_a}, 32'd0);
    check("async out_addr", out_addr_a, 32'd0);
    check("async err_cnt", {24'b0, err_cnt_a}, 32'd0);
    check("async in_ready", {31'b0, in_ready_a}, 32'd0);
    qa.delete();
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); #1;
    out_ready_a = 1'b1;
    req(0, 5'd2, 5'd4, 5'd5, 5'd6, 32'd0, 1, 32'h0062F233, 32'd0, "post-rst and");
    idle(4);

    check("qa drained", qa.size(), 32'd0);
    check("qb drained", qb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
